mem_sched: RTL and testbench

MEM_SCHED -- requirements
Module: mem_sched

---
 rtl/mem_sched_pkg.sv | 27 ++
 rtl/mem_sched_arb.sv | 29 ++
 rtl/mem_sched.sv | 139 +++++++++++++
 tb/tb_mem_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types for the memory scheduler: request/cache tags, block address/data
// and the scheduler FSM states.
package mem_sched_pkg;

    localparam int ADDR_W  = 16;
    localparam int BLOCK_W = 64;

    typedef logic [ADDR_W-1:0]  main_mem_block_addr_t;
    typedef logic [BLOCK_W-1:0] block_data_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_type_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } cache_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/mem_sched_arb.sv
// Two-requester round-robin arbiter; bit 0 is the icache, bit 1 the dcache.
// The last-grant pointer moves only when the granted request is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic last_q;

    // last_q = 1 means the dcache was granted last, so the icache wins a tie.
    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept_i && (grant_o != 2'b00)) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/mem_sched.sv
// Arbitrates icache/dcache block requests onto main memory with a single
// outstanding transaction, response tag checking and a lost-response timeout.
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 icache_req_valid,
    input  main_mem_block_addr_t icache_req_block_addr,
    output logic                 icache_req_ready,
    output logic                 icache_resp_valid,
    output block_data_t          icache_resp_block_data,

    input  logic                 dcache_req_valid,
    input  req_type_t            dcache_req_type,
    input  main_mem_block_addr_t dcache_req_block_addr,
    input  block_data_t          dcache_req_block_data,
    output logic                 dcache_req_ready,
    output logic                 dcache_resp_valid,
    output block_data_t          dcache_resp_block_data,

    output logic                 mem_req_valid,
    output cache_type_t          mem_req_cache_type,
    output req_type_t            mem_req_type,
    output main_mem_block_addr_t mem_req_block_addr,
    output block_data_t          mem_req_block_data,
    input  logic                 mem_resp_valid,
    input  cache_type_t          mem_resp_cache_type,
    input  block_data_t          mem_resp_block_data,

    output logic                 busy,
    output logic                 err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t         state_q;
    cache_type_t          cache_q;
    req_type_t            type_q;
    main_mem_block_addr_t addr_q;
    block_data_t          data_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 err_q;
    logic                 mem_valid_q;

    logic [1:0] grant;
    logic       accept;
    logic       resp_match;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({dcache_req_valid, icache_req_valid}),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // Ready is masked by rst so nothing is offered while reset is held.
    assign icache_req_ready = !rst && (state_q == IDLE) && grant[0];
    assign dcache_req_ready = !rst && (state_q == IDLE) && grant[1];
    assign accept = (icache_req_valid && icache_req_ready) ||
                    (dcache_req_valid && dcache_req_ready);

    assign resp_match = (state_q == WAIT) && mem_resp_valid &&
                        (mem_resp_cache_type == cache_q);

    assign icache_resp_valid      = resp_match && (cache_q == ICACHE);
    assign dcache_resp_valid      = resp_match && (cache_q == DCACHE);
    assign icache_resp_block_data = icache_resp_valid ? mem_resp_block_data : '0;
    assign dcache_resp_block_data = dcache_resp_valid ? mem_resp_block_data : '0;

    assign mem_req_valid      = mem_valid_q;
    assign mem_req_cache_type = cache_q;
    assign mem_req_type       = type_q;
    assign mem_req_block_addr = addr_q;
    assign mem_req_block_data = data_q;
    assign busy               = (state_q != IDLE);
    assign err                = err_q;

    // WAIT lasts at most TIMEOUT_CYCLES cycles: the counter starts at 0 and
    // the last chance for a matching response is when it reads TIMEOUT_CYCLES-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cache_q     <= ICACHE;
            type_q      <= READ;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            mem_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= ISSUE;
                        mem_valid_q <= 1'b1;
                        if (grant[0]) begin
                            cache_q <= ICACHE;
                            type_q  <= READ;
                            addr_q  <= icache_req_block_addr;
                            data_q  <= '0;
                        end else begin
                            cache_q <= DCACHE;
                            type_q  <= dcache_req_type;
                            addr_q  <= dcache_req_block_addr;
                            data_q  <= dcache_req_block_data;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                WAIT: begin
                    if (resp_match) begin
                        state_q <= IDLE;
                    end else begin
                        if (mem_resp_valid) begin
                            err_q <= 1'b1;
                        end
                        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sched.sv
// Randomised scoreboard bench for mem_sched: a driver pushes expected memory
// requests and cache responses, a negedge monitor pops and compares them.
module tb_mem_sched;
    import mem_sched_pkg::*;

    localparam int TMO = 16;
    localparam int M_RESP = 0, M_MISMATCH = 1, M_TIMEOUT = 2, M_RESET = 3;

    typedef struct packed {
        cache_type_t          c;
        req_type_t            t;
        logic                 chk;
        main_mem_block_addr_t a;
        block_data_t          d;
    } memreq_t;

    typedef struct packed {
        cache_type_t c;
        logic        chk;
        block_data_t d;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic icache_req_valid = 1'b0;
    main_mem_block_addr_t icache_req_block_addr = '0;
    logic icache_req_ready, icache_resp_valid;
    block_data_t icache_resp_block_data;
    logic dcache_req_valid = 1'b0;
    req_type_t dcache_req_type = READ;
    main_mem_block_addr_t dcache_req_block_addr = '0;
    block_data_t dcache_req_block_data = '0;
    logic dcache_req_ready, dcache_resp_valid;
    block_data_t dcache_resp_block_data;
    logic mem_req_valid;
    cache_type_t mem_req_cache_type;
    req_type_t mem_req_type;
    main_mem_block_addr_t mem_req_block_addr;
    block_data_t mem_req_block_data;
    logic mem_resp_valid = 1'b0;
    cache_type_t mem_resp_cache_type = ICACHE;
    block_data_t mem_resp_block_data = '0;
    logic busy, err;

    int total = 0;
    int bad = 0;
    memreq_t expReqQ[$];
    resp_t expRespQ[$];
    bit lastDcache;
    bit expErr;

    mem_sched #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .icache_req_valid       (icache_req_valid),
        .icache_req_block_addr  (icache_req_block_addr),
        .icache_req_ready       (icache_req_ready),
        .icache_resp_valid      (icache_resp_valid),
        .icache_resp_block_data (icache_resp_block_data),
        .dcache_req_valid       (dcache_req_valid),
        .dcache_req_type        (dcache_req_type),
        .dcache_req_block_addr  (dcache_req_block_addr),
        .dcache_req_block_data  (dcache_req_block_data),
        .dcache_req_ready       (dcache_req_ready),
        .dcache_resp_valid      (dcache_resp_valid),
        .dcache_resp_block_data (dcache_resp_block_data),
        .mem_req_valid          (mem_req_valid),
        .mem_req_cache_type     (mem_req_cache_type),
        .mem_req_type           (mem_req_type),
        .mem_req_block_addr     (mem_req_block_addr),
        .mem_req_block_data     (mem_req_block_data),
        .mem_resp_valid         (mem_resp_valid),
        .mem_resp_cache_type    (mem_resp_cache_type),
        .mem_resp_block_data    (mem_resp_block_data),
        .busy                   (busy),
        .err                    (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every presented memory request / cache response must match the head of its queue.
    always @(negedge clk) begin : monitor
        memreq_t r;
        resp_t p;
        if (!rst) begin
            if (mem_req_valid) begin
                if (expReqQ.size() == 0) begin
                    checkOutput("mem_req_valid_unexpected", mem_req_valid, 0);
                end else begin
                    r = expReqQ.pop_front();
                    checkOutput("mem_req_cache", mem_req_cache_type, r.c);
                    checkOutput("mem_req_type", mem_req_type, r.t);
                    checkOutput("mem_req_addr", mem_req_block_addr, r.a);
                    if (r.chk) checkOutput("mem_req_data", mem_req_block_data, r.d);
                end
            end
            if (icache_resp_valid || dcache_resp_valid) begin
                if (expRespQ.size() == 0) begin
                    checkOutput("resp_valid_unexpected", {icache_resp_valid, dcache_resp_valid}, 0);
                end else begin
                    p = expRespQ.pop_front();
                    checkOutput("resp_icache_valid", icache_resp_valid, p.c == ICACHE);
                    checkOutput("resp_dcache_valid", dcache_resp_valid, p.c == DCACHE);
                    if (p.chk)
                        checkOutput("resp_data", (p.c == DCACHE) ? dcache_resp_block_data
                                                                 : icache_resp_block_data, p.d);
                end
            end
        end
    end

    task automatic resetDut();
        rst = 1'b1;
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b0;
        mem_resp_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lastDcache = 1'b1;
        expErr     = 1'b0;
    endtask

    task automatic staleIdleResp();
        mem_resp_valid      = 1'b1;
        mem_resp_cache_type = cache_type_t'($urandom_range(0, 1));
        mem_resp_block_data = {$urandom, $urandom};
        @(posedge clk);
        #1 mem_resp_valid = 1'b0;
        checkOutput("idle_stale_err", err, expErr);
        checkOutput("idle_stale_busy", busy, 0);
    endtask

    // One full transaction; called at posedge+1 with the DUT in IDLE.
    task automatic applyStimulus(input bit iv, input bit dv, input req_type_t dtype,
                                 input main_mem_block_addr_t iaddr, input main_mem_block_addr_t daddr,
                                 input block_data_t ddata, input int mode, input int delay,
                                 input block_data_t rdata, input bit issueStale);
        cache_type_t win;
        memreq_t r;
        resp_t p;
        int c;
        icache_req_valid      = iv;
        icache_req_block_addr = iaddr;
        dcache_req_valid      = dv;
        dcache_req_type       = dtype;
        dcache_req_block_addr = daddr;
        dcache_req_block_data = ddata;
        if (iv && dv) win = lastDcache ? ICACHE : DCACHE;
        else          win = iv ? ICACHE : DCACHE;
        @(negedge clk);
        checkOutput("icache_ready", icache_req_ready, win == ICACHE);
        checkOutput("dcache_ready", dcache_req_ready, win == DCACHE);
        r.c   = win;
        r.t   = (win == ICACHE) ? READ : dtype;
        r.chk = (win == DCACHE);
        r.a   = (win == ICACHE) ? iaddr : daddr;
        r.d   = ddata;
        expReqQ.push_back(r);
        lastDcache = (win == DCACHE);
        @(posedge clk);
        #1;
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b0;
        if (issueStale) begin
            mem_resp_valid      = 1'b1;
            mem_resp_cache_type = win;
        end
        @(posedge clk);
        #1 mem_resp_valid = 1'b0;
        checkOutput("req_issued_once", expReqQ.size(), 0);
        c = 0;
        if (mode == M_RESP || mode == M_MISMATCH) begin
            if (mode == M_MISMATCH) begin
                mem_resp_valid      = 1'b1;
                mem_resp_cache_type = (win == ICACHE) ? DCACHE : ICACHE;
                mem_resp_block_data = {$urandom, $urandom};
                @(posedge clk);
                #1 mem_resp_valid = 1'b0;
                expErr = 1'b1;
                checkOutput("mismatch_err", err, 1);
                checkOutput("mismatch_still_busy", busy, 1);
                c = 1;
            end
            repeat (delay - 1 - c) @(posedge clk);
            #1;
            mem_resp_valid      = 1'b1;
            mem_resp_cache_type = win;
            mem_resp_block_data = rdata;
            p.c   = win;
            p.chk = !(win == DCACHE && r.t == WRITE);
            p.d   = rdata;
            expRespQ.push_back(p);
            @(posedge clk);
            #1 mem_resp_valid = 1'b0;
            checkOutput("resp_forwarded", expRespQ.size(), 0);
            checkOutput("done_busy", busy, 0);
        end else if (mode == M_TIMEOUT) begin
            repeat (TMO - 1) @(posedge clk);
            #1 checkOutput("timeout_not_early", busy, 1);
            @(posedge clk);
            #1;
            expErr = 1'b1;
            checkOutput("timeout_busy", busy, 0);
        end else begin
            repeat (delay - 1) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            expErr     = 1'b0;
            lastDcache = 1'b1;
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_mem_req_valid", mem_req_valid, 0);
            checkOutput("rst_err", err, 0);
            @(posedge clk);
            #1 rst = 1'b0;
            mem_resp_valid      = 1'b1;
            mem_resp_cache_type = win;
            mem_resp_block_data = rdata;
            @(negedge clk);
            checkOutput("rst_stale_ready", {icache_resp_valid, dcache_resp_valid}, 0);
            @(posedge clk);
            #1 mem_resp_valid = 1'b0;
            checkOutput("rst_stale_busy", busy, 0);
        end
        checkOutput("err_flag", err, expErr);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int mode, delay;
        bit iv, dv;
        lastDcache = 1'b1;
        expErr     = 1'b0;
        rst = 1'b1;
        icache_req_valid = 1'b1;
        dcache_req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_icache_ready", icache_req_ready, 0);
        checkOutput("reset_dcache_ready", dcache_req_ready, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_mem_req_valid", mem_req_valid, 0);
        resetDut();

        applyStimulus(1, 0, READ, 16'h0010, 16'h0, '0, M_RESP, 3, {8{8'hAB}}, 0);
        resetDut();
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1, WRITE, 16'h0100 + 16'(i), 16'h0200 + 16'(i), {2{$urandom}},
                          M_RESP, 2, {$urandom, $urandom}, 0);
        applyStimulus(0, 1, WRITE, 16'h0, 16'h0020, {8{8'h55}}, M_RESP, 1, '0, 0);
        applyStimulus(1, 0, READ, 16'h0030, 16'h0, '0, M_TIMEOUT, 1, '0, 0);
        applyStimulus(1, 0, READ, 16'h0040, 16'h0, '0, M_RESP, TMO, {2{$urandom}}, 0);
        resetDut();
        applyStimulus(0, 1, READ, 16'h0, 16'h0050, '0, M_MISMATCH, 4, {2{$urandom}}, 0);
        applyStimulus(1, 1, READ, 16'h0060, 16'h0070, '0, M_RESET, 3, {2{$urandom}}, 0);
        applyStimulus(1, 1, READ, 16'h0080, 16'h0090, '0, M_RESP, 1, {2{$urandom}}, 1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) staleIdleResp();
            do begin
                iv = 1'($urandom_range(0, 1));
                dv = 1'($urandom_range(0, 1));
            end while (!iv && !dv);
            mode  = $urandom_range(0, 9);
            mode  = (mode < 6) ? M_RESP : (mode < 8) ? M_MISMATCH : (mode < 9) ? M_TIMEOUT : M_RESET;
            delay = (mode == M_MISMATCH) ? $urandom_range(2, TMO) : $urandom_range(1, TMO);
            applyStimulus(iv, dv, req_type_t'($urandom_range(0, 1)),
                          main_mem_block_addr_t'($urandom), main_mem_block_addr_t'($urandom),
                          {$urandom, $urandom}, mode, delay, {$urandom, $urandom},
                          1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("req_queue_empty", expReqQ.size(), 0);
        checkOutput("resp_queue_empty", expRespQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
